// File: rtl/seven_seg_scan_if.sv
// Signal bundle between the digit-scan controller and its system/decoder side.
// The controller takes the slave view; the host and the shared segment decoder take the master view.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
);
    logic                    load;
    logic [4*NUM_DIGITS-1:0] digits_in;
    logic                    lz_en;
    logic [3:0]              bcd_out;
    logic [6:0]              seg_in;
    logic [6:0]              seg_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    bcd_err;

    modport master (
        output load, digits_in, lz_en, seg_in,
        input  bcd_out, seg_out, an_out, bcd_err
    );

    modport slave (
        input  load, digits_in, lz_en, seg_in,
        output bcd_out, seg_out, an_out, bcd_err
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: blanked digit slots, frame-synchronous
// display updates, leading-zero suppression and a dash for non-BCD digits.
//
// state | meaning
// IDLE  | nothing loaded yet, anodes off, prescaler parked at 0
// BLANK | first BLANK_CYC cycles of a slot, anodes off to kill ghosting
// DRIVE | remainder of the slot, current digit's anode on
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV        = 1000,
    parameter int BLANK_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_scan_if.slave     bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0]         CNT_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]         DRIVE_1ST  = CW'(BLANK_CYC);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] AN_ONE     = {{(NUM_DIGITS-1){1'b0}}, 1'b1};
    localparam logic [6:0]            SEG_DASH   = 7'b0000001;

    typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

    state_t                  state;
    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] active;
    logic [4*NUM_DIGITS-1:0] pending;
    logic                    pend_vld;
    logic                    supp;

    logic [3:0]              digit;
    logic                    hi_zero;
    logic                    bad_digit;

    always_comb begin
        digit       = active[{idx, 2'b00} +: 4];
        hi_zero     = ((active >> {idx, 2'b00}) == '0);
        bad_digit   = (digit > 4'd9);
        bus.bcd_out = rst ? 4'd0 : digit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            active      <= '0;
            pending     <= '0;
            pend_vld    <= 1'b0;
            supp        <= 1'b0;
            bus.an_out  <= '1;
            bus.seg_out <= 7'b0000000;
            bus.bcd_err <= 1'b0;
        end else begin
            bus.an_out  <= '1;
            bus.bcd_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        state    <= BLANK;
                        cnt      <= '0;
                        idx      <= '0;
                        active   <= bus.digits_in;
                        pending  <= bus.digits_in;
                        pend_vld <= 1'b0;
                    end
                end
                BLANK: begin
                    cnt <= cnt + 1'b1;
                    // Suppression decision is frozen for the whole slot at slot start.
                    if (cnt == '0)
                        supp <= bus.lz_en && (idx != '0) && hi_zero;
                    if (cnt == BLANK_LAST)
                        state <= DRIVE;
                end
                DRIVE: begin
                    if (!supp) begin
                        bus.an_out  <= ~(AN_ONE << idx);
                        bus.seg_out <= bad_digit ? SEG_DASH : bus.seg_in;
                        bus.bcd_err <= bad_digit && (cnt == DRIVE_1ST);
                    end
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= BLANK;
                        if (idx == IDX_LAST) begin
                            idx <= '0;
                            if (pend_vld) begin
                                active   <= pending;
                                pend_vld <= 1'b0;
                            end
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed after the case so a load on the frame-boundary edge re-arms pending.
            if (bus.load && (state != IDLE)) begin
                pending  <= bus.digits_in;
                pend_vld <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Directed bench for seven_seg_scan_ctrl with DIV=10, BLANK_CYC=2, four digits.
// Each digit slot is checked cycle by cycle against hand-derived anode/segment/error values.
module tb_seven_seg_scan_ctrl;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    seven_seg_scan_if #(.NUM_DIGITS(4)) bus ();

    seven_seg_scan_ctrl #(.NUM_DIGITS(4), .DIV(10), .BLANK_CYC(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared BCD-to-seven-segment decoder, {a,b,c,d,e,f,g} active-high.
    always_comb begin
        case (bus.bcd_out)
            4'd0:    bus.seg_in = 7'b1111110;
            4'd1:    bus.seg_in = 7'b0110000;
            4'd2:    bus.seg_in = 7'b1101101;
            4'd3:    bus.seg_in = 7'b1111001;
            4'd4:    bus.seg_in = 7'b0110011;
            4'd5:    bus.seg_in = 7'b1011011;
            4'd6:    bus.seg_in = 7'b1011111;
            4'd7:    bus.seg_in = 7'b1110000;
            4'd8:    bus.seg_in = 7'b1111111;
            4'd9:    bus.seg_in = 7'b1111011;
            default: bus.seg_in = 7'b0000000;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One 10-cycle slot, entered in its count-0 cycle. Optionally pulses load at cycle ld_c.
    task automatic slot(input logic [3:0] an_exp, input logic [6:0] seg_exp, input logic err_exp,
                        input int ld_c, input logic [15:0] ld_val);
        for (int c = 0; c < 10; c++) begin
            if (c == ld_c) begin
                bus.digits_in = ld_val;
                bus.load      = 1'b1;
            end
            tick();
            bus.load = 1'b0;
            check("an_out", 16'(bus.an_out), (c < 2) ? 16'hF : 16'(an_exp));
            if (c >= 2 && an_exp != 4'hF)
                check("seg_out", 16'(bus.seg_out), 16'(seg_exp));
            check("bcd_err", 16'(bus.bcd_err), 16'((c == 2) && err_exp));
        end
    endtask

    localparam logic [6:0] S0 = 7'b1111110, S1 = 7'b0110000, S2 = 7'b1101101, S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011, S5 = 7'b1011011, S6 = 7'b1011111, S7 = 7'b1110000;
    localparam logic [6:0] S9 = 7'b1111011, SD = 7'b0000001;

    initial begin
        rst           = 1'b1;
        bus.load      = 1'b0;
        bus.digits_in = '0;
        bus.lz_en     = 1'b0;
        tick();
        tick();
        check("rst_an", 16'(bus.an_out), 16'hF);
        check("rst_seg", 16'(bus.seg_out), 16'h0);
        check("rst_err", 16'(bus.bcd_err), 16'h0);
        check("rst_bcd", 16'(bus.bcd_out), 16'h0);

        // No load: display stays dark for 5 slot periods.
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_an", 16'(bus.an_out), 16'hF);
            check("idle_seg", 16'(bus.seg_out), 16'h0);
        end

        // First load leaves IDLE and displays immediately.
        bus.digits_in = 16'h1234;
        bus.load      = 1'b1;
        tick();
        bus.load = 1'b0;
        slot(4'b1110, S4, 0, -1, 0);
        slot(4'b1101, S3, 0, -1, 0);
        slot(4'b1011, S2, 0, -1, 0);
        slot(4'b0111, S1, 0, -1, 0);

        // 0007 loaded at frame start goes to pending; this frame still shows 1234.
        bus.lz_en = 1'b1;
        slot(4'b1110, S4, 0, 0, 16'h0007);
        slot(4'b1101, S3, 0, -1, 0);
        slot(4'b1011, S2, 0, -1, 0);
        slot(4'b0111, S1, 0, -1, 0);

        // Leading zeros suppressed.
        slot(4'b1110, S7, 0, -1, 0);
        slot(4'b1111, S0, 0, -1, 0);
        slot(4'b1111, S0, 0, -1, 0);
        slot(4'b1111, S0, 0, -1, 0);

        // Suppression off: zeros visible. 00A5 queued for the next frame.
        bus.lz_en = 1'b0;
        slot(4'b1110, S7, 0, 0, 16'h00A5);
        slot(4'b1101, S0, 0, -1, 0);
        slot(4'b1011, S0, 0, -1, 0);
        slot(4'b0111, S0, 0, -1, 0);

        // Non-BCD digit shows a dash and flags once per frame, two frames running.
        slot(4'b1110, S5, 0, -1, 0);
        slot(4'b1101, SD, 1, -1, 0);
        slot(4'b1011, S0, 0, -1, 0);
        slot(4'b0111, S0, 0, -1, 0);
        slot(4'b1110, S5, 0, 0, 16'h1111);
        slot(4'b1101, SD, 1, -1, 0);
        slot(4'b1011, S0, 0, -1, 0);
        slot(4'b0111, S0, 0, -1, 0);

        // Mid-frame load does not tear; load on the copy edge waits a frame.
        slot(4'b1110, S1, 0, -1, 0);
        slot(4'b1101, S1, 0, -1, 0);
        slot(4'b1011, S1, 0, 0, 16'h2222);
        slot(4'b0111, S1, 0, 9, 16'h3333);

        // Back-to-back loads (last cycle of slot 2, first of slot 3): last one wins.
        slot(4'b1110, S2, 0, -1, 0);
        slot(4'b1101, S2, 0, -1, 0);
        slot(4'b1011, S2, 0, 9, 16'h5555);
        slot(4'b0111, S2, 0, 0, 16'h6666);

        slot(4'b1110, S6, 0, -1, 0);
        slot(4'b1101, S6, 0, -1, 0);
        slot(4'b1011, S6, 0, -1, 0);
        slot(4'b0111, S6, 0, -1, 0);

        // Reset in the middle of DRIVE, with a competing load that must be ignored.
        repeat (5) tick();
        check("pre_rst_an", 16'(bus.an_out), 16'b1110);
        rst           = 1'b1;
        bus.digits_in = 16'h0009;
        bus.load      = 1'b1;
        tick();
        check("midrst_an", 16'(bus.an_out), 16'hF);
        check("midrst_seg", 16'(bus.seg_out), 16'h0);
        check("midrst_err", 16'(bus.bcd_err), 16'h0);
        check("midrst_bcd", 16'(bus.bcd_out), 16'h0);
        rst      = 1'b0;
        bus.load = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            check("postrst_an", 16'(bus.an_out), 16'hF);
        end

        // Restart from digit 0 after reset.
        bus.lz_en     = 1'b1;
        bus.digits_in = 16'h0009;
        bus.load      = 1'b1;
        tick();
        bus.load = 1'b0;
        slot(4'b1110, S9, 0, -1, 0);
        slot(4'b1111, S0, 0, -1, 0);
        slot(4'b1111, S0, 0, -1, 0);
        slot(4'b1111, S0, 0, -1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_scan_ctrl.md
SEVEN_SEG_SCAN_CTRL -- requirements
Module: seven_seg_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 4: number of multiplexed display digits; legal range 2..8.
REQ-002 Parameter DIV, default 1000: clk cycles per digit slot, including blanking; DIV > BLANK_CYC.
REQ-003 Parameter BLANK_CYC, default 2: anode-off cycles at the start of each digit slot, for ghost suppression.
REQ-004 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 load  input  1  single-cycle strobe that captures digits_in.
REQ-007 digits_in  input  4*NUM_DIGITS  packed BCD; bits [3:0] are digit 0 (least significant).
REQ-008 lz_en  input  1  leading-zero suppression enable; sampled at the start of each slot.
REQ-009 bcd_out  output  4  BCD code for the current digit, driven to the shared BCD-to-7-segment decoder.
REQ-010 seg_in  input  7  decoder result, ordered {a,b,c,d,e,f,g}, active-high; combinational from bcd_out.
REQ-011 seg_out  output  7  registered segment drive to the pins, active-high.
REQ-012 an_out  output  NUM_DIGITS  registered anode enables, active-low, at most one low at a time.
REQ-013 bcd_err  output  1  one-cycle pulse when a digit greater than 9 starts being displayed.

Function
REQ-014 A prescaler SHALL count 0..DIV-1 and wrap; slot_start is the cycle in which the count equals 0.
REQ-015 The FSM SHALL use the states IDLE, BLANK and DRIVE.
- IDLE -> BLANK on the first accepted load, with count forced to 0.
- BLANK -> DRIVE when count equals BLANK_CYC-1.
- DRIVE -> BLANK when count equals DIV-1, and the digit index advances.
REQ-016 The digit index SHALL run 0..NUM_DIGITS-1 and wrap to 0 after NUM_DIGITS-1; a frame is one full pass of the index.
REQ-017 On load, digits_in SHALL be captured into a pending register and a pending flag SHALL be set.
REQ-018 The pending register SHALL be copied to the active register only when the index wraps to 0, or immediately on the IDLE exit; there is no tearing within a frame.
REQ-019 A load arriving in the same cycle as the frame-boundary copy SHALL go to pending and take effect at the next frame; the older pending value is copied.
REQ-020 Back-to-back loads SHALL overwrite pending; the last one wins.
REQ-021 bcd_out SHALL be combinational from the active register and the digit index.
REQ-022 In BLANK, an_out SHALL be all ones; seg_out SHALL hold its previous value.
REQ-023 In DRIVE, an_out[index] SHALL be 0 and all other bits 1.
- seg_out SHALL be seg_in, registered once.
- Latency is 1 cycle from the bcd_out change to the seg_out/an_out update.
REQ-024 If the current digit is greater than 9, seg_out SHALL be 7'b0000001 (dash) in place of seg_in.
- bcd_err SHALL pulse in the first DRIVE cycle of that slot.
REQ-025 With lz_en set, a digit k > 0 SHALL be suppressed (an_out all ones for the whole slot) when k and every higher digit are 0.
- Digit 0 is never suppressed.
- lz_en SHALL be evaluated at slot_start.
REQ-026 The FSM SHALL never return to IDLE except through reset.

Reset
REQ-027 While rst is high: state IDLE; prescaler, index, active and pending registers and pending flag = 0.
REQ-028 While rst is high: an_out all ones; seg_out = 7'b0000000; bcd_out = 0; bcd_err = 0.
REQ-029 Reset SHALL take priority over load in the same cycle.
- Assertion mid-slot SHALL blank the display on the next edge.
REQ-030 In IDLE, an_out SHALL remain all ones.

Verification
REQ-031 Reset with no load for 5*DIV cycles -> an_out = 4'b1111 and seg_out = 0 throughout.
REQ-032 DIV=10, BLANK_CYC=2, load digits_in=16'h1234.
- Per 10-cycle slot: 2 cycles an_out=1111, then 8 cycles of the active anode.
- Anodes 1110, 1101, 1011, 0111 in order.
- seg_out = 0110011 (4), 1111001 (3), 1101101 (2), 0110000 (1).
REQ-033 Load 16'h0007 with lz_en=1 -> only digit 0 lights (1110000); slots 1-3 keep an_out=1111; with lz_en=0, the 0s show as 1111110.
REQ-034 Load 16'h00A5 -> digit 1 shows 0000001, bcd_err pulses once per frame, and digit 0 shows 1011011.
REQ-035 Load 16'h1111, then load 16'h2222 while the index is 2 -> digits 2 and 3 still show 1 for that frame; 2 appears from digit 0 of the next frame.
REQ-036 Assert rst mid-DRIVE -> next edge gives an_out=1111 and seg_out=0, and a subsequent load restarts from digit 0.
